// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types for the skid-buffered pipeline stage register
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY,
    PS_ONE,
    PS_TWO
  } pipe_state_e;

  // Entries the stage can hold at once (head + skid).
  localparam int unsigned PIPE_DEPTH = 2;

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating event counter with synchronous clear
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - pipeline stage register with valid/ready and 2-entry skid buffer
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int CTRL_W   = 3,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 16,
  parameter int CLR_DATA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              cnt_clr
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  pipe_state_e state_q, state_d;
  entry_t      head_q, head_d;
  entry_t      skid_q, skid_d;
  entry_t      in_entry;
  logic        acc;
  logic        pop;

  assign in_entry = {in_ctrl, in_addr, in_data};

  // Ready depends on registered state only, so out_ready never reaches in_ready.
  assign in_ready  = (state_q != PS_TWO);
  assign out_valid = (state_q != PS_EMPTY);
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d     = PS_EMPTY;
      head_d.ctrl = '0;
      skid_d.ctrl = '0;
      if (CLR_DATA != 0) begin
        head_d.addr = '0;
        head_d.data = '0;
        skid_d.addr = '0;
        skid_d.data = '0;
      end
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (acc) begin
            head_d  = in_entry;
            state_d = PS_ONE;
          end
        end
        PS_ONE: begin
          if (acc && pop) begin
            head_d = in_entry;
          end else if (acc) begin
            skid_d  = in_entry;
            state_d = PS_TWO;
          end else if (pop) begin
            state_d = PS_EMPTY;
          end
        end
        PS_TWO: begin
          if (pop) begin
            head_d  = skid_q;
            state_d = PS_ONE;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PS_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  // Stale head ctrl after a plain pop must not leak downstream.
  assign out_ctrl = out_valid ? head_q.ctrl : '0;
  assign out_addr = head_q.addr;
  assign out_data = head_q.data;

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(out_valid & ~out_ready),
    .clr(cnt_clr),
    .cnt(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - randomized and directed bench for pipe_stage_skid_reg
module tb_pipe_stage_skid_reg;

  localparam int DW  = 32;
  localparam int CW  = 3;
  localparam int AW  = 5;
  localparam int NW  = 4;
  localparam int SAT = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic [NW-1:0] stall_cnt;
  logic          cnt_clr;

  pipe_stage_skid_reg #(
    .DATA_W(DW), .CTRL_W(CW), .ADDR_W(AW), .CNT_W(NW), .CLR_DATA(0)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_addr(in_addr), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_addr(out_addr), .out_data(out_data),
    .stall_cnt(stall_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_cnt;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(q.size() < 2));
    chk({tag, ".out_ctrl"},  64'(out_ctrl),  (q.size() > 0) ? 64'(q[0].c) : 64'd0);
    chk({tag, ".out_addr"},  64'(out_addr),  64'(m_addr));
    chk({tag, ".out_data"},  64'(out_data),  64'(m_data));
    chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_cnt));
  endtask

  task automatic model_reset();
    q.delete();
    m_addr = '0;
    m_data = '0;
    m_cnt  = 0;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic ordy, input logic fl, input logic clr);
    in_valid  = v;
    in_ctrl   = c;
    in_addr   = a;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    cnt_clr   = clr;
  endtask

  // One clock: the reference model sees exactly what the DUT saw at the edge.
  task automatic cycle(input string tag);
    int n;
    bit acc, pop;
    @(posedge clk);
    n   = q.size();
    acc = in_valid && (n < 2);
    pop = (n > 0) && out_ready;
    if (cnt_clr) m_cnt = 0;
    else if ((n > 0) && !out_ready && (m_cnt < SAT)) m_cnt++;
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{in_ctrl, in_addr, in_data});
    end
    if (q.size() > 0) begin
      m_addr = q[0].a;
      m_data = q[0].d;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, '0, '0, '0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // Async reset mid-stream with two entries held.
    drive(1, 3'b101, 5'd1, 32'h1, 0, 0, 0); cycle("t1.push1");
    drive(1, 3'b110, 5'd2, 32'h2, 0, 0, 0); cycle("t1.push2");
    drive(0, '0, '0, '0, 0, 0, 0);          cycle("t1.stall");
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("t1.async_out_valid", 64'(out_valid), 64'd0);
    chk("t1.async_in_ready",  64'(in_ready),  64'd1);
    chk("t1.async_out_ctrl",  64'(out_ctrl),  64'd0);
    chk("t1.async_stall_cnt", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check_all("t1.after");

    // Streaming with downstream always ready.
    drive(1, 3'b001, 5'd3, 32'h11, 1, 0, 0); cycle("t2.a");
    chk("t2.d11", 64'(out_data), 64'h11);
    drive(1, 3'b010, 5'd4, 32'h22, 1, 0, 0); cycle("t2.b");
    chk("t2.d22", 64'(out_data), 64'h22);
    drive(1, 3'b011, 5'd5, 32'h33, 1, 0, 0); cycle("t2.c");
    chk("t2.d33", 64'(out_data), 64'h33);
    chk("t2.rdy", 64'(in_ready), 64'd1);
    drive(0, '0, '0, '0, 1, 0, 0);            cycle("t2.drain");

    // Back-pressure fills head and skid, then drains in order.
    drive(1, 3'b100, 5'd6, 32'hA, 0, 0, 0); cycle("t3.a");
    drive(1, 3'b101, 5'd7, 32'hB, 0, 0, 0); cycle("t3.b");
    chk("t3.full_rdy", 64'(in_ready), 64'd0);
    drive(1, 3'b110, 5'd8, 32'hC, 0, 0, 0); cycle("t3.c_held");
    chk("t3.headA", 64'(out_data), 64'hA);
    drive(1, 3'b110, 5'd8, 32'hC, 1, 0, 0); cycle("t3.popA");
    chk("t3.headB", 64'(out_data), 64'hB);
    drive(1, 3'b110, 5'd8, 32'hC, 1, 0, 0); cycle("t3.popB");
    chk("t3.headC", 64'(out_data), 64'hC);
    drive(0, '0, '0, '0, 1, 0, 0);           cycle("t3.popC");

    // Flush while full overrides a simultaneous push and pop.
    drive(1, 3'b111, 5'd9,  32'h5, 0, 0, 0); cycle("t4.f1");
    drive(1, 3'b111, 5'd10, 32'h6, 0, 0, 0); cycle("t4.f2");
    drive(1, 3'b111, 5'd11, 32'hD, 1, 1, 0); cycle("t4.flush");
    chk("t4.out_valid", 64'(out_valid), 64'd0);
    chk("t4.out_ctrl",  64'(out_ctrl),  64'd0);
    chk("t4.in_ready",  64'(in_ready),  64'd1);
    drive(0, '0, '0, '0, 1, 0, 0);            cycle("t4.idle");
    chk("t4.no_d", 64'(out_valid), 64'd0);

    // Stall counter saturation and clear priority.
    drive(1, 3'b001, 5'd12, 32'h77, 0, 0, 1); cycle("t5.load");
    drive(0, '0, '0, '0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle("t5.stall");
    chk("t5.sat", 64'(stall_cnt), 64'd15);
    drive(0, '0, '0, '0, 0, 0, 1);            cycle("t5.clr");
    chk("t5.cleared", 64'(stall_cnt), 64'd0);
    drive(0, '0, '0, '0, 1, 0, 0);            cycle("t5.drain");

    // Random traffic against the queue model.
    for (int i = 0; i < 10000; i++) begin
      drive(($urandom_range(0, 9) < 7),
            CW'($urandom), AW'($urandom), DW'($urandom),
            ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 99) < 3),
            ($urandom_range(0, 99) < 2));
      cycle("t6.rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
